// File: rtl/ctrl_fsm8.sv
// ctrl_fsm8: multi-cycle control FSM for the 8-bit computer, with a retired-instruction counter.
// Optional memory timeout with sticky fault when CTRL_MEM_TIMEOUT_EN is defined.
module ctrl_fsm8 (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  logic [7:0] instr_i,
  input  logic       zero_i,
  input  logic       mem_ack_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic       reg_we_o,
  output logic [1:0] pc_src_o,
  output logic       alu_src_imm_o,
  output logic [1:0] alu_op_o,
  output logic       mem_to_reg_o,
  output logic       halted_o,
  output logic       fault_o,
  output logic [2:0] state_o,
  output logic [7:0] instr_count_o
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_HALT
  } state_t;
  localparam logic [2:0] OP_R = 3'd0, OP_LW = 3'd2, OP_SW = 3'd3, OP_BEQ = 3'd4,
                         OP_J = 3'd5, OP_NOP = 3'd6, OP_HALT = 3'd7;
  state_t state_q, state_d;
  logic [7:0] cnt_q;
  logic retire;
  logic [2:0] op;
  logic unused_imm;
  assign op = instr_i[7:5];
  assign unused_imm = ^instr_i[4:2];
  assign state_o = state_q;
  assign instr_count_o = cnt_q;
  assign halted_o = state_q == S_HALT;
`ifdef CTRL_MEM_TIMEOUT_EN
  logic [3:0] wcnt_q;
  logic fault_q;
  logic tmo;
  assign tmo = mem_req_o && !mem_ack_i && wcnt_q == 4'd14;
  assign fault_o = fault_q;
  // The counter only runs while a request is pending, so leaving FETCH/MEM clears it.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wcnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      wcnt_q  <= (mem_req_o && !mem_ack_i) ? wcnt_q + 4'd1 : 4'd0;
      fault_q <= fault_q | tmo;
    end
  end
`else
  assign fault_o = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_q + {7'd0, retire};
    end
  end
  always_comb begin
    state_d       = state_q;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    iord_o        = 1'b0;
    ir_we_o       = 1'b0;
    pc_we_o       = 1'b0;
    reg_we_o      = 1'b0;
    pc_src_o      = 2'd0;
    alu_src_imm_o = 1'b0;
    alu_op_o      = 2'd0;
    mem_to_reg_o  = 1'b0;
    retire        = 1'b0;
    case (state_q)
      S_IDLE: state_d = start_i ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_req_o = 1'b1;
        ir_we_o   = mem_ack_i;
        pc_we_o   = mem_ack_i;
        state_d   = mem_ack_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_BEQ: state_d = S_BRANCH;
          OP_J: begin
            pc_we_o  = 1'b1;
            pc_src_o = 2'd2;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          OP_NOP: begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_HALT: begin
            retire  = 1'b1;
            state_d = S_HALT;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_src_imm_o = op != OP_R;
        alu_op_o      = op == OP_R ? instr_i[1:0] : 2'd0;
        state_d       = (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req_o     = 1'b1;
        iord_o        = 1'b1;
        mem_we_o      = op == OP_SW;
        alu_src_imm_o = 1'b1;
        retire        = mem_ack_i && op == OP_SW;
        state_d       = !mem_ack_i ? S_MEM : op == OP_SW ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_we_o     = 1'b1;
        mem_to_reg_o = op == OP_LW;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_op_o = 2'd1;
        pc_we_o  = zero_i;
        pc_src_o = zero_i ? 2'd1 : 2'd0;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
`ifdef CTRL_MEM_TIMEOUT_EN
    if (tmo) state_d = S_HALT;
`endif
  end
endmodule
